wavelet_pe_sink_ctrl: RTL and testbench

//  Level sequencer for the wavelet PE output sink. Runs NUM_LEVELS decomposition levels and

---
 rtl/wavelet_pe_pkg.sv | 37 +++
 rtl/wavelet_level_counter.sv | 82 ++++++++
 rtl/wavelet_pe_sink_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_wavelet_pe_sink_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wavelet_pe_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : wavelet_pe_pkg
//  Description : Shared types and helpers for the wavelet PE sink controller.
//                Holds the sequencer state encoding, default buffer geometry
//                and the per-level output-length halving function.
//  Revision    : 1.0  initial release
// ============================================================================
package wavelet_pe_pkg;

    localparam int c_DEF_OBUFF_CELL_COUNT = 2048;
    localparam int c_DEF_APPROX_BASE_A    = 1024;
    localparam int c_DEF_APPROX_BASE_B    = 1536;
    localparam int c_DEF_MAX_LEVELS       = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_RUN   = 3'd2,
        S_FLUSH = 3'd3,
        S_DRAIN = 3'd4,
        S_NEXT  = 3'd5,
        S_FIN   = 3'd6
    } sink_ctrl_state_t;

    // One decimation stage yields ceil(in_len / 2) outputs per band. The sum
    // is formed one bit wider than the operand so in_len+1 cannot wrap; the
    // caller truncates the result to its address width.
    function automatic logic [31:0] halve_len(input logic [31:0] in_len);
        logic [32:0] w_sum;
        w_sum = {1'b0, in_len} + 33'd1;
        return w_sum[32:1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/wavelet_level_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : wavelet_level_counter
//  Description : Counts FIR high-pass and low-pass output strobes within one
//                decomposition level, flags when both bands reached the level
//                length, and flags strobes that would exceed it.
//  Ports       : clk, rst            clock / async active-high reset
//                i_init              level INIT cycle: counters restart
//                i_run               level RUN cycle: strobes counted
//                i_flush             FLUSH cycle: HP strobes are illegal
//                i_hp_valid          HP output strobe
//                i_lp_valid          LP output strobe
//                i_cur_len           outputs expected per band this level
//                o_hp_cnt            HP strobes counted so far
//                o_all_done          both bands reached i_cur_len
//                o_overrun           1-cycle flag: strobe beyond i_cur_len
//  Revision    : 1.0  initial release
// ============================================================================
module wavelet_level_counter #(
    parameter int CNT_WIDTH = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_init,
    input  logic                 i_run,
    input  logic                 i_flush,
    input  logic                 i_hp_valid,
    input  logic                 i_lp_valid,
    input  logic [CNT_WIDTH-1:0] i_cur_len,
    output logic [CNT_WIDTH-1:0] o_hp_cnt,
    output logic                 o_all_done,
    output logic                 o_overrun
);

    logic [CNT_WIDTH-1:0] r_hp_cnt;
    logic [CNT_WIDTH-1:0] r_lp_cnt;

    logic                 w_count_win;
    logic                 w_active;
    logic [CNT_WIDTH-1:0] w_hp_base;
    logic [CNT_WIDTH-1:0] w_lp_base;
    logic                 w_hp_full;
    logic                 w_lp_full;
    logic                 w_hp_inc;
    logic                 w_lp_inc;
    logic                 w_hp_ovr;
    logic                 w_lp_ovr;

    // HP strobes are only legal in INIT/RUN; during FLUSH the sink is forcing
    // the HP column itself. LP keeps counting through FLUSH.
    assign w_count_win = i_init | i_run;
    assign w_active    = w_count_win | i_flush;

    // In INIT the counters restart from zero, yet a strobe in that same cycle
    // still counts, so the comparison base is zero rather than the old count.
    assign w_hp_base = i_init ? '0 : r_hp_cnt;
    assign w_lp_base = i_init ? '0 : r_lp_cnt;
    assign w_hp_full = (w_hp_base == i_cur_len);
    assign w_lp_full = (w_lp_base == i_cur_len);

    assign w_hp_inc = i_hp_valid & w_count_win & ~w_hp_full;
    assign w_lp_inc = i_lp_valid & w_active & ~w_lp_full;
    assign w_hp_ovr = i_hp_valid & ((w_count_win & w_hp_full) | i_flush);
    assign w_lp_ovr = i_lp_valid & w_active & w_lp_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hp_cnt <= '0;
            r_lp_cnt <= '0;
        end else if (w_active) begin
            r_hp_cnt <= w_hp_base + {{(CNT_WIDTH-1){1'b0}}, w_hp_inc};
            r_lp_cnt <= w_lp_base + {{(CNT_WIDTH-1){1'b0}}, w_lp_inc};
        end
    end

    assign o_hp_cnt   = r_hp_cnt;
    assign o_all_done = (r_hp_cnt == i_cur_len) && (r_lp_cnt == i_cur_len);
    assign o_overrun  = w_hp_ovr | w_lp_ovr;

endmodule
`default_nettype wire

// File: rtl/wavelet_pe_sink_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : wavelet_pe_sink_ctrl
//  Description : Level sequencer for the wavelet PE output sink. Steps through
//                the requested decomposition levels, derives per-level output
//                lengths, drives the sink's base/offset resets, HP force-count
//                and the ping-pong approximation base, and watches the FIR
//                output strobes to detect level end.
//  Ports       : clk, rst                  clock / async active-high reset
//                start                     begin transform (IDLE only)
//                num_levels, signal_len    job description, sampled on start
//                level_abort               upstream ended the level early
//                fir_hp/lp_output_valid    FIR output strobes
//                cur/prev_outputs_len      per-band length, this/previous level
//                obuff_w_*_rst             sink reset pulses (INIT)
//                obuff_w_hp_force_cen      HP force-count enable (FLUSH)
//                obuff_w_approx_addr       LP write base, this level
//                approx_rd_base            LP base of previous level
//                level_start               FIR source may begin this level
//                cur_level                 running level index
//                busy, done                not IDLE / end-of-transform pulse
//                err_overrun               sticky strobe-overrun flag
//  Revision    : 1.0  initial release
// ============================================================================
module wavelet_pe_sink_ctrl
    import wavelet_pe_pkg::*;
#(
    parameter int OBUFF_CELL_COUNT = c_DEF_OBUFF_CELL_COUNT,
    parameter int APPROX_BASE_A    = c_DEF_APPROX_BASE_A,
    parameter int APPROX_BASE_B    = c_DEF_APPROX_BASE_B,
    parameter int MAX_LEVELS       = c_DEF_MAX_LEVELS,
    parameter int OBUFF_ADDR_WIDTH = $clog2(OBUFF_CELL_COUNT),
    parameter int LVL_WIDTH        = $clog2(MAX_LEVELS + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [LVL_WIDTH-1:0]        num_levels,
    input  logic [OBUFF_ADDR_WIDTH-1:0] signal_len,
    input  logic                        level_abort,
    input  logic                        fir_hp_output_valid,
    input  logic                        fir_lp_output_valid,
    output logic [OBUFF_ADDR_WIDTH-1:0] cur_outputs_len,
    output logic [OBUFF_ADDR_WIDTH-1:0] prev_outputs_len,
    output logic                        obuff_w_offset_rst,
    output logic                        obuff_w_hp_base_reg_rst,
    output logic                        obuff_w_lp_base_reg_rst,
    output logic                        obuff_w_hp_force_cen,
    output logic [OBUFF_ADDR_WIDTH-1:0] obuff_w_approx_addr,
    output logic [OBUFF_ADDR_WIDTH-1:0] approx_rd_base,
    output logic                        level_start,
    output logic [LVL_WIDTH-1:0]        cur_level,
    output logic                        busy,
    output logic                        done,
    output logic                        err_overrun
);

    localparam logic [OBUFF_ADDR_WIDTH-1:0] c_BASE_A = OBUFF_ADDR_WIDTH'(APPROX_BASE_A);
    localparam logic [OBUFF_ADDR_WIDTH-1:0] c_BASE_B = OBUFF_ADDR_WIDTH'(APPROX_BASE_B);

    sink_ctrl_state_t r_state;
    sink_ctrl_state_t w_state_nxt;

    logic [LVL_WIDTH-1:0]        r_num_levels;
    logic [LVL_WIDTH-1:0]        r_level;
    logic [OBUFF_ADDR_WIDTH-1:0] r_cur;
    logic [OBUFF_ADDR_WIDTH-1:0] r_prev;
    logic [OBUFF_ADDR_WIDTH-1:0] r_approx_wr;
    logic [OBUFF_ADDR_WIDTH-1:0] r_approx_rd;
    logic [OBUFF_ADDR_WIDTH-1:0] r_flush_rem;
    logic                        r_err;

    logic                        w_start_ok;
    logic                        w_last_level;
    logic                        w_level_done;
    logic                        w_abort_flush;
    logic [OBUFF_ADDR_WIDTH-1:0] w_hp_cnt;
    logic                        w_all_done;
    logic                        w_overrun;

    assign w_start_ok    = (r_state == S_IDLE) && start;
    assign w_last_level  = ((r_level + LVL_WIDTH'(1)) == r_num_levels);
    // A strobe still in flight means the sink is not finished with the level.
    assign w_level_done  = w_all_done && !fir_hp_output_valid && !fir_lp_output_valid;
    assign w_abort_flush = (w_hp_cnt < r_cur);

    wavelet_level_counter #(
        .CNT_WIDTH (OBUFF_ADDR_WIDTH)
    ) u_level_counter (
        .clk        (clk),
        .rst        (rst),
        .i_init     (r_state == S_INIT),
        .i_run      (r_state == S_RUN),
        .i_flush    (r_state == S_FLUSH),
        .i_hp_valid (fir_hp_output_valid),
        .i_lp_valid (fir_lp_output_valid),
        .i_cur_len  (r_cur),
        .o_hp_cnt   (w_hp_cnt),
        .o_all_done (w_all_done),
        .o_overrun  (w_overrun)
    );

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and control outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt             = r_state;
        obuff_w_offset_rst      = 1'b0;
        obuff_w_hp_base_reg_rst = 1'b0;
        obuff_w_lp_base_reg_rst = 1'b0;
        obuff_w_hp_force_cen    = 1'b0;
        level_start             = 1'b0;
        done                    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (num_levels == '0) ? S_FIN : S_INIT;
                end
            end
            S_INIT: begin
                obuff_w_offset_rst      = 1'b1;
                obuff_w_lp_base_reg_rst = 1'b1;
                // The HP base only restarts at the first level; deeper
                // levels append their detail coefficients behind it.
                obuff_w_hp_base_reg_rst = (r_level == '0);
                level_start             = 1'b1;
                w_state_nxt             = S_RUN;
            end
            S_RUN: begin
                if (level_abort) begin
                    w_state_nxt = w_abort_flush ? S_FLUSH : S_DRAIN;
                end else if (w_level_done) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_FLUSH: begin
                obuff_w_hp_force_cen = 1'b1;
                if (r_flush_rem <= OBUFF_ADDR_WIDTH'(1)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_state_nxt = S_NEXT;
            end
            S_NEXT: begin
                w_state_nxt = w_last_level ? S_FIN : S_INIT;
            end
            S_FIN: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Level bookkeeping: lengths, level index, ping-pong bases, flush count
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_num_levels <= '0;
            r_level      <= '0;
            r_cur        <= '0;
            r_prev       <= '0;
            r_approx_wr  <= c_BASE_A;
            r_approx_rd  <= c_BASE_B;
            r_flush_rem  <= '0;
        end else begin
            if (w_start_ok) begin
                r_num_levels <= num_levels;
                r_level      <= '0;
                r_cur        <= OBUFF_ADDR_WIDTH'(halve_len(32'(signal_len)));
                r_prev       <= signal_len;
                r_approx_wr  <= c_BASE_A;
                r_approx_rd  <= c_BASE_B;
            end else if (r_state == S_NEXT) begin
                r_prev      <= r_cur;
                r_cur       <= OBUFF_ADDR_WIDTH'(halve_len(32'(r_cur)));
                r_level     <= r_level + LVL_WIDTH'(1);
                r_approx_wr <= r_approx_rd;
                r_approx_rd <= r_approx_wr;
            end

            if ((r_state == S_RUN) && level_abort && w_abort_flush) begin
                r_flush_rem <= r_cur - w_hp_cnt;
            end else if (r_state == S_FLUSH) begin
                r_flush_rem <= r_flush_rem - OBUFF_ADDR_WIDTH'(1);
            end
        end
    end

    // Sticky overrun flag; a freshly accepted job starts clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_start_ok) begin
            r_err <= 1'b0;
        end else if (w_overrun) begin
            r_err <= 1'b1;
        end
    end

    assign cur_outputs_len     = r_cur;
    assign prev_outputs_len    = r_prev;
    assign obuff_w_approx_addr = r_approx_wr;
    assign approx_rd_base      = r_approx_rd;
    assign cur_level           = r_level;
    assign busy                = (r_state != S_IDLE);
    assign err_overrun         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_wavelet_pe_sink_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_wavelet_pe_sink_ctrl
//  Description : Scoreboard bench for wavelet_pe_sink_ctrl. Stimulus queues
//                the expected level/flush/done events; a monitor compares
//                them when the DUT raises level_start, ends a force-count
//                burst, or pulses done.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wavelet_pe_sink_ctrl;

    localparam int          c_AW = 11;
    localparam int          c_LW = 4;
    localparam logic [10:0] c_BA = 11'd1024;
    localparam logic [10:0] c_BB = 11'd1536;
    localparam int          K_LEVEL = 0;
    localparam int          K_FLUSH = 1;
    localparam int          K_DONE  = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [c_LW-1:0] num_levels;
    logic [c_AW-1:0] signal_len;
    logic            level_abort;
    logic            hp_v;
    logic            lp_v;
    logic [c_AW-1:0] cur_len;
    logic [c_AW-1:0] prev_len;
    logic            off_rst;
    logic            hp_rst;
    logic            lp_rst;
    logic            force_cen;
    logic [c_AW-1:0] approx_addr;
    logic [c_AW-1:0] rd_base;
    logic            level_start;
    logic [c_LW-1:0] cur_level;
    logic            busy;
    logic            done;
    logic            err;

    wavelet_pe_sink_ctrl dut (
        .clk                     (clk),
        .rst                     (rst),
        .start                   (start),
        .num_levels              (num_levels),
        .signal_len              (signal_len),
        .level_abort             (level_abort),
        .fir_hp_output_valid     (hp_v),
        .fir_lp_output_valid     (lp_v),
        .cur_outputs_len         (cur_len),
        .prev_outputs_len        (prev_len),
        .obuff_w_offset_rst      (off_rst),
        .obuff_w_hp_base_reg_rst (hp_rst),
        .obuff_w_lp_base_reg_rst (lp_rst),
        .obuff_w_hp_force_cen    (force_cen),
        .obuff_w_approx_addr     (approx_addr),
        .approx_rd_base          (rd_base),
        .level_start             (level_start),
        .cur_level               (cur_level),
        .busy                    (busy),
        .done                    (done),
        .err_overrun             (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int lvl;
        int cur;
        int prev;
        int aa;
        int rb;
        int hpr;
        int err;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input int kind, input int lvl, input int cur,
                                input int prev, input int hpr, input int e);
        exp_t x;
        x.kind = kind;
        x.lvl  = lvl;
        x.cur  = cur;
        x.prev = prev;
        x.aa   = (lvl % 2 == 1) ? int'(c_BB) : int'(c_BA);
        x.rb   = (lvl % 2 == 1) ? int'(c_BA) : int'(c_BB);
        x.hpr  = hpr;
        x.err  = e;
        return x;
    endfunction

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    exp_t m_e;
    int   fl_run = 0;

    always @(negedge clk) begin
        if (rst) begin
            fl_run = 0;
        end else begin
            if (level_start) begin
                if (q.size() == 0) begin
                    chk("unexpected_level_start", 1, 0);
                end else begin
                    m_e = q.pop_front();
                    chk("event_kind_level", K_LEVEL, m_e.kind);
                    chk("cur_level", cur_level, m_e.lvl);
                    chk("cur_outputs_len", cur_len, m_e.cur);
                    chk("prev_outputs_len", prev_len, m_e.prev);
                    chk("approx_addr", approx_addr, m_e.aa);
                    chk("approx_rd_base", rd_base, m_e.rb);
                    chk("hp_base_reg_rst", hp_rst, m_e.hpr);
                    chk("lp_base_reg_rst", lp_rst, 1);
                    chk("offset_rst", off_rst, 1);
                end
            end else begin
                chk("offset_rst_idle", off_rst, 0);
            end
            if (force_cen) begin
                fl_run++;
            end else if (fl_run != 0) begin
                if (q.size() == 0) begin
                    chk("unexpected_flush", 1, 0);
                end else begin
                    m_e = q.pop_front();
                    chk("event_kind_flush", K_FLUSH, m_e.kind);
                    chk("flush_cycles", fl_run, m_e.cur);
                end
                fl_run = 0;
            end
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    m_e = q.pop_front();
                    chk("event_kind_done", K_DONE, m_e.kind);
                    chk("err_at_done", err, m_e.err);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int len, input int nl);
        signal_len = c_AW'(len);
        num_levels = c_LW'(nl);
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_level();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (level_start) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) chk("timeout_level_start", 0, 1);
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (done) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) chk("timeout_done", 0, 1);
        tick();
    endtask

    task automatic drive_strobes(input int n_hp, input int n_lp, input bit inj);
        int n;
        n = (n_hp > n_lp) ? n_hp : n_lp;
        for (int i = 0; i < n; i++) begin
            hp_v = (i < n_hp);
            lp_v = (i < n_lp);
            if (inj && i == 1) begin
                start      = 1'b1;
                signal_len = 11'd5;
                num_levels = 4'd1;
            end
            tick();
            start = 1'b0;
        end
        hp_v = 1'b0;
        lp_v = 1'b0;
    endtask

    task automatic run_xform(input int len, input int nl, input bit inj);
        int in_l;
        int c;
        in_l = len;
        for (int l = 0; l < nl; l++) begin
            c = (in_l + 1) >> 1;
            q.push_back(mk(K_LEVEL, l, c, in_l, (l == 0) ? 1 : 0, 0));
            in_l = c;
        end
        q.push_back(mk(K_DONE, 0, 0, 0, 0, 0));
        pulse_start(len, nl);
        chk("err_clear_on_start", err, 0);
        in_l = len;
        for (int l = 0; l < nl; l++) begin
            c = (in_l + 1) >> 1;
            wait_level();
            drive_strobes(c, c, inj && (l == 1));
            in_l = c;
        end
        wait_done();
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        num_levels  = '0;
        signal_len  = '0;
        level_abort = 1'b0;
        hp_v        = 1'b0;
        lp_v        = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_cur_len", cur_len, 0);
        chk("rst_prev_len", prev_len, 0);
        chk("rst_approx_addr", approx_addr, c_BA);
        chk("rst_rd_base", rd_base, c_BB);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_level_start", level_start, 0);
        chk("rst_force_cen", force_cen, 0);
        chk("rst_hp_rst", hp_rst, 0);
        rst = 1'b0;
        tick();

        // 16 samples, 3 levels; a stray start mid-run must be ignored
        run_xform(16, 3, 1'b1);
        chk("idle_after_done", busy, 0);

        // Zero levels: straight to FIN
        q.push_back(mk(K_DONE, 0, 0, 0, 0, 0));
        pulse_start(16, 0);
        chk("nl0_done", done, 1);
        chk("nl0_busy", busy, 1);
        tick();
        chk("nl0_idle", busy, 0);

        // Early abort after 5 of 8 HP outputs -> 3 force-count cycles
        q.push_back(mk(K_LEVEL, 0, 8, 16, 1, 0));
        q.push_back(mk(K_FLUSH, 0, 3, 0, 0, 0));
        q.push_back(mk(K_DONE, 0, 0, 0, 0, 0));
        pulse_start(16, 1);
        wait_level();
        drive_strobes(5, 0, 1'b0);
        level_abort = 1'b1;
        tick();
        level_abort = 1'b0;
        wait_done();

        // Nine HP strobes on an 8-output level -> sticky overrun
        q.push_back(mk(K_LEVEL, 0, 8, 16, 1, 0));
        q.push_back(mk(K_DONE, 0, 0, 0, 0, 1));
        pulse_start(16, 1);
        wait_level();
        drive_strobes(9, 8, 1'b0);
        wait_done();
        repeat (3) tick();
        chk("err_sticky", err, 1);

        // Odd length; the accepted start clears the overrun flag
        run_xform(13, 2, 1'b0);

        // Reset in the middle of RUN
        q.push_back(mk(K_LEVEL, 0, 8, 16, 1, 0));
        pulse_start(16, 2);
        wait_level();
        drive_strobes(3, 3, 1'b0);
        chk("busy_in_run", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_cur_len", cur_len, 0);
        chk("midrst_prev_len", prev_len, 0);
        chk("midrst_approx_addr", approx_addr, c_BA);
        chk("midrst_rd_base", rd_base, c_BB);
        chk("midrst_cur_level", cur_level, 0);
        chk("midrst_level_start", level_start, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        run_xform(16, 1, 1'b0);

        repeat (4) tick();
        chk("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
